// File: rtl/pwd_pkg.sv
// Shared types, message codes and width helper for the password lock controller.
package pwd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET      = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_SHOW_MSG = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_e;

    localparam logic [2:0] MSG_NONE = 3'd0;
    localparam logic [2:0] MSG_PWD  = 3'd1;
    localparam logic [2:0] MSG_OK   = 3'd2;
    localparam logic [2:0] MSG_ERR  = 3'd3;
    localparam logic [2:0] MSG_TMO  = 3'd4;
    localparam logic [2:0] MSG_LOCK = 3'd5;
    localparam logic [2:0] MSG_FAIL = 3'd6;

    // Width of the shared seconds counter: enough to hold the largest preload.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// Shared seconds countdown: load N, decrement on each tick while non-zero,
// flag expiry on a tick that finds the counter already at zero.
module sec_countdown #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_1s,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    // Counter register: a load always wins over a tick in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= CNT_ZERO;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick_1s && (count_q != CNT_ZERO)) begin
            count_q <= count_q - CNT_ONE;
        end else begin
            count_q <= count_q;
        end
    end

    // Expiry is flagged in the tick cycle itself so the FSM reacts on that edge;
    // it does not look at load, which keeps the FSM->load->expire path acyclic.
    assign expire = tick_1s && (count_q == CNT_ZERO);
    assign count  = count_q;

endmodule

// File: rtl/pwd_lock_controller.sv
// Password set / verify / change controller with attempt limiting, timed
// lockout and inactivity relock. All outputs come straight from registers.
module pwd_lock_controller
    import pwd_pkg::*;
#(
    parameter int PWD_WIDTH               = 16,
    parameter int TIMEOUT_SECONDS         = 30,
    parameter int MESSAGE_DISPLAY_SECONDS = 2,
    parameter int MAX_ATTEMPTS            = 3,
    parameter int LOCKOUT_SECONDS         = 60
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  tick_1s,
    input  logic                                  btn_enter_pulse,
    input  logic                                  btn_cancel_pulse,
    input  logic [PWD_WIDTH-1:0]                  sw,
    input  logic                                  has_pass,
    input  logic [PWD_WIDTH-1:0]                  stored_password,
    output logic                                  pwd_set_mode,
    output logic                                  unlocked,
    output logic                                  save_password,
    output logic [PWD_WIDTH-1:0]                  password_to_save,
    output logic [2:0]                            msg,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts_left,
    output logic [cnt_w(TIMEOUT_SECONDS, LOCKOUT_SECONDS, MESSAGE_DISPLAY_SECONDS)-1:0] seconds_left
);

    localparam int CNT_W = cnt_w(TIMEOUT_SECONDS, LOCKOUT_SECONDS, MESSAGE_DISPLAY_SECONDS);
    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [CNT_W-1:0]     LD_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     LD_TMO  = CNT_W'(TIMEOUT_SECONDS);
    localparam logic [CNT_W-1:0]     LD_MSG  = CNT_W'(MESSAGE_DISPLAY_SECONDS);
    localparam logic [CNT_W-1:0]     LD_LOCK = CNT_W'(LOCKOUT_SECONDS);
    localparam logic [ATT_W-1:0]     ATT_MAX = ATT_W'(MAX_ATTEMPTS);
    localparam logic [ATT_W-1:0]     ATT_ONE = ATT_W'(1);
    localparam logic [ATT_W-1:0]     ATT_ZERO = {ATT_W{1'b0}};
    localparam logic [PWD_WIDTH-1:0] PWD_ZERO = {PWD_WIDTH{1'b0}};

    state_e               state_q, state_d;
    state_e               ret_q, ret_d;
    logic [ATT_W-1:0]     att_q, att_d;
    logic [2:0]           msg_q, msg_d;
    logic                 save_q, save_d;
    logic [PWD_WIDTH-1:0] pts_q, pts_d;
    logic                 set_mode_q, unlocked_q;
    logic                 load_s;
    logic [CNT_W-1:0]     load_val_s;
    logic [CNT_W-1:0]     count_s;
    logic                 expire_s;

    sec_countdown #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick_1s  (tick_1s),
        .load     (load_s),
        .load_val (load_val_s),
        .count    (count_s),
        .expire   (expire_s)
    );

    // Next-state decode: cancel beats enter, and any button beats timer expiry.
    // Every transition that starts a timed phase requests a counter load here.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        att_d      = att_q;
        msg_d      = msg_q;
        save_d     = 1'b0;
        pts_d      = pts_q;
        load_s     = 1'b0;
        load_val_s = LD_ZERO;
        case (state_q)
            ST_IDLE: begin
                msg_d = MSG_NONE;
                if (btn_cancel_pulse) begin
                    state_d = ST_IDLE;
                end else if (btn_enter_pulse) begin
                    load_s = 1'b1;
                    if (!has_pass) begin
                        state_d    = ST_SET;
                        msg_d      = MSG_PWD;
                        load_val_s = LD_TMO;
                    end else if (sw == stored_password) begin
                        att_d      = ATT_MAX;
                        state_d    = ST_SHOW_MSG;
                        ret_d      = ST_UNLOCKED;
                        msg_d      = MSG_OK;
                        load_val_s = LD_MSG;
                    end else if (att_q <= ATT_ONE) begin
                        att_d      = ATT_ZERO;
                        state_d    = ST_LOCKOUT;
                        msg_d      = MSG_LOCK;
                        load_val_s = LD_LOCK;
                    end else begin
                        att_d      = att_q - ATT_ONE;
                        state_d    = ST_SHOW_MSG;
                        ret_d      = ST_IDLE;
                        msg_d      = MSG_FAIL;
                        load_val_s = LD_MSG;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SET: begin
                msg_d = MSG_PWD;
                if (btn_cancel_pulse) begin
                    state_d = ST_IDLE;
                    msg_d   = MSG_NONE;
                    load_s  = 1'b1;
                end else if (btn_enter_pulse || expire_s) begin
                    state_d    = ST_SHOW_MSG;
                    ret_d      = ST_IDLE;
                    load_s     = 1'b1;
                    load_val_s = LD_MSG;
                    if (!btn_enter_pulse) begin
                        msg_d = MSG_TMO;
                    end else if (sw != PWD_ZERO) begin
                        save_d = 1'b1;
                        pts_d  = sw;
                        msg_d  = MSG_OK;
                    end else begin
                        msg_d = MSG_ERR;
                    end
                end else begin
                    state_d = ST_SET;
                end
            end
            ST_UNLOCKED: begin
                msg_d = MSG_NONE;
                if (btn_cancel_pulse) begin
                    state_d = ST_IDLE;
                    load_s  = 1'b1;
                end else if (btn_enter_pulse) begin
                    state_d    = ST_SET;
                    msg_d      = MSG_PWD;
                    load_s     = 1'b1;
                    load_val_s = LD_TMO;
                end else if (expire_s) begin
                    state_d    = ST_SHOW_MSG;
                    ret_d      = ST_IDLE;
                    msg_d      = MSG_TMO;
                    load_s     = 1'b1;
                    load_val_s = LD_MSG;
                end else begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_SHOW_MSG: begin
                if (expire_s) begin
                    load_s = 1'b1;
                    msg_d  = MSG_NONE;
                    case (ret_q)
                        ST_UNLOCKED: begin
                            state_d    = ST_UNLOCKED;
                            load_val_s = LD_TMO;
                        end
                        ST_SET: begin
                            state_d    = ST_SET;
                            msg_d      = MSG_PWD;
                            load_val_s = LD_TMO;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_SHOW_MSG;
                end
            end
            ST_LOCKOUT: begin
                msg_d = MSG_LOCK;
                if (expire_s) begin
                    att_d   = ATT_MAX;
                    state_d = ST_IDLE;
                    msg_d   = MSG_NONE;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ret_d   = ST_IDLE;
                msg_d   = MSG_NONE;
                load_s  = 1'b1;
            end
        endcase
    end

    // FSM and output registers; mode flags are decoded from the next state so
    // they change on the same edge as the transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            att_q      <= ATT_MAX;
            msg_q      <= MSG_NONE;
            save_q     <= 1'b0;
            pts_q      <= PWD_ZERO;
            set_mode_q <= 1'b0;
            unlocked_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            att_q      <= att_d;
            msg_q      <= msg_d;
            save_q     <= save_d;
            pts_q      <= pts_d;
            set_mode_q <= (state_d == ST_SET);
            unlocked_q <= (state_d == ST_UNLOCKED);
        end
    end

    assign pwd_set_mode     = set_mode_q;
    assign unlocked         = unlocked_q;
    assign save_password    = save_q;
    assign password_to_save = pts_q;
    assign msg              = msg_q;
    assign attempts_left    = att_q;
    assign seconds_left     = count_s;

endmodule

// File: doc/pwd_lock_controller.md
# pwd_lock_controller

Parametrised password set/verify/change controller with attempt limiting and timed lockout. Sits between the debounced button pulses and switch bank on one side and the password register and 7-segment message mux on the other. It generalises single-shot password entry to:
- configurable password width;
- unlock by comparison against the stored value;
- password change while unlocked;
- auto-relock;
- lockout after `MAX_ATTEMPTS` consecutive failures.

## Interface
Parameters:
- `PWD_WIDTH`, 16, password and switch width.
- `TIMEOUT_SECONDS`, 30, inactivity limit in SET and UNLOCKED.
- `MESSAGE_DISPLAY_SECONDS`, 2, message hold time.
- `MAX_ATTEMPTS`, 3, consecutive failed unlocks before lockout (≥1).
- `LOCKOUT_SECONDS`, 60, lockout duration.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick_1s` in 1: one-cycle pulse per second.
- `btn_enter_pulse` in 1: enter / confirm (one-cycle).
- `btn_cancel_pulse` in 1: cancel / relock (one-cycle).
- `sw` in `PWD_WIDTH`: candidate password.
- `has_pass` in 1: a password is stored.
- `stored_password` in `PWD_WIDTH`: current stored value.
- `pwd_set_mode` out 1: high in SET.
- `unlocked` out 1: high in UNLOCKED.
- `save_password` out 1: one-cycle write strobe.
- `password_to_save` out `PWD_WIDTH`: value written; holds until the next save.
- `msg` out 3: display message code.
- `attempts_left` out `$clog2(MAX_ATTEMPTS+1)`.
- `seconds_left` out `CNT_W = $clog2(max(TIMEOUT_SECONDS, LOCKOUT_SECONDS, MESSAGE_DISPLAY_SECONDS)+1)`: active countdown value.

## Operation
Message codes:
- `MSG_NONE`=0, `MSG_PWD`=1, `MSG_OK`=2, `MSG_ERR`=3, `MSG_TMO`=4, `MSG_LOCK`=5, `MSG_FAIL`=6.

States: IDLE, SET, UNLOCKED, SHOW_MSG, LOCKOUT. SHOW_MSG carries a registered `ret_state`.

- **IDLE** (locked), `msg`=NONE.
  - Enter with `!has_pass` → SET, counter=`TIMEOUT_SECONDS`.
  - Enter with `has_pass` and `sw==stored_password`:
    - `attempts_left`=`MAX_ATTEMPTS`;
    - → SHOW_MSG(OK), `ret_state`=UNLOCKED.
  - Enter with `has_pass` and mismatch:
    - `attempts_left` decrements;
    - if it reaches 0 → LOCKOUT, counter=`LOCKOUT_SECONDS`;
    - otherwise → SHOW_MSG(FAIL), `ret_state`=IDLE.
- **SET**: `msg`=PWD, `pwd_set_mode`=1.
  - Enter with `sw≠0`: `save_password` pulse, `password_to_save`=`sw` → SHOW_MSG(OK), `ret_state`=IDLE.
  - Enter with `sw==0` → SHOW_MSG(ERR), `ret_state`=IDLE.
  - Cancel → IDLE immediately, no save.
  - Timer expiry → SHOW_MSG(TMO), `ret_state`=IDLE.
- **UNLOCKED**: `unlocked`=1, `msg`=NONE.
  - Enter → SET, counter reloaded (password change).
  - Cancel → IDLE.
  - Timer expiry → SHOW_MSG(TMO), `ret_state`=IDLE.
  - Any button reloads the timer.
- **SHOW_MSG**: `msg` holds the code; buttons ignored; timer expiry → `ret_state`, `msg`=NONE.
  - Entering UNLOCKED or SET from here loads `TIMEOUT_SECONDS`.
- **LOCKOUT**: `msg`=LOCK; buttons ignored.
  - Expiry → `attempts_left`=`MAX_ATTEMPTS`, → IDLE.

Countdown rule (all timers, one shared counter):
- load N;
- each `tick_1s` with counter>0 decrements;
- a `tick_1s` with counter==0 is expiry;
- expiry occurs on the (N+1)th tick after load.

## Timing
- All outputs registered. Transitions and outputs update on the clock edge that samples the pulse, i.e. visible the following cycle.
- `save_password`: exactly one cycle, coincident with `password_to_save` update and `msg`=OK.
- Simultaneous events:
  - cancel beats enter;
  - either button beats `tick_1s` expiry in the same cycle;
  - a button in SET/UNLOCKED also reloads the counter.
- `has_pass` and `stored_password` are sampled only on the enter cycle in IDLE.
- Reset values (asynchronous on `reset_n` low, all outputs):
  - state=IDLE;
  - `pwd_set_mode`=0, `unlocked`=0, `save_password`=0;
  - `password_to_save`=0;
  - `msg`=NONE;
  - `attempts_left`=`MAX_ATTEMPTS`;
  - `seconds_left`=0.
- Reset mid-SET: no save strobe is emitted.
- Illegal state → IDLE on the next clock.

## Structure
- Package `pwd_pkg`:
  - state enum;
  - `msg` code constants (3-bit);
  - shared `CNT_W` function.
- Sub-module `sec_countdown`:
  - inputs: `clk`, `reset_n`, `tick_1s`, `load`, `load_val[CNT_W]`;
  - outputs: `count`, `expire` (one-cycle pulse);
  - `load` beats tick.
- The FSM holds `ret_state`, `attempts_left` and output registers.

## Test plan
- First set: `has_pass`=0, enter with `sw`=16'hA5A5 → `save_password` one cycle, `password_to_save`=A5A5, `msg`=2 for 3 ticks then 0, state IDLE.
- Unlock: `has_pass`=1, `stored_password`=A5A5, enter with `sw`=A5A5 → `msg`=2, then `unlocked`=1 after expiry. Then 31 ticks idle → `msg`=4, `unlocked`=0.
- Lockout: three enters with `sw`=0001 → `attempts_left` 2,1,0, `msg` 6,6,5. Enters during lockout ignored. 61 ticks → `attempts_left`=3, `msg`=0.
- Change: while unlocked, enter then `sw`=0, enter → `msg`=3, no save. Repeat with `sw`=1234 → save 1234.
- Collisions: enter+cancel same cycle in SET → IDLE, no save. Enter coincident with expiry tick in SET → save, not TMO.
- Reset: assert `reset_n` low mid-SET and mid-LOCKOUT → all outputs at reset values immediately, `attempts_left`=3.
